bcd_convert_seq: RTL

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly downstream of the 4x4 shift-add multiplier. It takes the 8-bit product when the multiplier's done pulse arrives and produces decimal digits for the display stage.
- One conversion at a time, with a start/done handshake and a busy flag.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 32 +++
 rtl/bcd_convert_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit arithmetic constants and active-low
// 7-segment patterns (bit 0 = segment a ... bit 6 = segment g).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADJUST = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADJ_THRESH  = 5;
    localparam int ADJ_ADD     = 3;

    // Active-low segment patterns, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Single-digit BCD to active-low 7-segment decoder with a blank input.
// Codes 10-15 are not valid BCD and are shown as all segments off.
module seg7_decoder
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    input  logic                   blank,
    output logic [6:0]             seg
);

    // Pattern lookup; blank overrides the digit value
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        seg = SEG_BLANK;
        if (!blank) begin
            unique case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One conversion at a time: start is accepted in IDLE, each input bit costs
// an ADJUST and a SHIFT cycle, and the result is registered on the final
// shift together with a one-cycle done pulse.
// Optional feature: define SEG7_EN to add a leading-zero-blanked,
// active-low 7-segment output (seg) decoded from the registered bcd.
module bcd_convert_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          done,
    output logic                          busy
`ifdef SEG7_EN
    ,
    output logic [7*DIGITS-1:0]           seg
`endif
);

    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W  = BCD_DIGIT_W * DIGITS;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   work_bin;
    logic [BCD_W-1:0]   work_bcd;
    logic [BCD_W-1:0]   adj_bcd;
    logic [BCD_W-1:0]   shifted_bcd;
    logic [CNT_W-1:0]   count;
    logic               last_bit;

    // Add-3 cell per digit: any digit >= 5 gets +3 so the next shift carries correctly
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        logic [BCD_DIGIT_W-1:0] cur;
        assign cur = work_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W];
        assign adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W] =
            (cur >= BCD_DIGIT_W'(ADJ_THRESH)) ? cur + BCD_DIGIT_W'(ADJ_ADD) : cur;
    end

    // BCD half of {work_bcd, work_bin} after a one-bit left shift
    assign shifted_bcd = {work_bcd[BCD_W-2:0], work_bin[WIDTH-1]};
    assign last_bit    = (count == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: alternate ADJUST/SHIFT once per input bit
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = ADJUST;
            ADJUST:  next_state = SHIFT;
            SHIFT:   next_state = last_bit ? DONE : ADJUST;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath, result register and handshake flags
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: only a handful of flops here, so all of them are reset; an abort leaves no stale work.
        if (!rst) begin
            work_bin <= '0;
            work_bcd <= '0;
            count    <= '0;
            bcd      <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        work_bin <= bin;
                        work_bcd <= '0;
                        count    <= '0;
                        busy     <= 1'b1;
                    end
                end
                ADJUST: begin
                    work_bcd <= adj_bcd;
                end
                SHIFT: begin
                    work_bcd <= shifted_bcd;
                    work_bin <= work_bin << 1;
                    count    <= count + CNT_W'(1);
                    if (last_bit) begin
                        bcd  <= shifted_bcd;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEG7_EN
    logic [DIGITS-1:0] blank;

    // Leading-zero blanking: a digit blanks only if it and every higher digit is zero
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank[i]   = zero_above;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_seg
        seg7_decoder u_dec (
            .digit (bcd[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .blank (blank[d]),
            .seg   (seg[d*7 +: 7])
        );
    end
`endif

endmodule
